// File: rtl/elastic_pipeline_stage_if.sv
// Handshake bundle for one elastic pipeline stage.
// Upstream side, downstream side and status, grouped for a single port.
interface elastic_pipeline_stage_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic             Flush;
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] In_Data;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Out_Data;
  logic [CW-1:0]    Count;
  logic             Flushed;

  modport master (
    output Flush,
    output In_Valid,
    output In_Data,
    output Out_Ready,
    input  In_Ready,
    input  Out_Valid,
    input  Out_Data,
    input  Count,
    input  Flushed
  );

  modport slave (
    input  Flush,
    input  In_Valid,
    input  In_Data,
    input  Out_Ready,
    output In_Ready,
    output Out_Valid,
    output Out_Data,
    output Count,
    output Flushed
  );
endinterface

// File: rtl/elastic_pipeline_stage.sv
// Elastic inter-stage register: DEPTH-entry FIFO with valid/ready,
// flush, and a bubble value driven whenever it is empty.
module elastic_pipeline_stage #(
  parameter int          WIDTH  = 32,
  parameter int          DEPTH  = 2,
  parameter logic [31:0] BUBBLE = 32'h0000_0013
) (
  input logic CLK,
  input logic RST,
  elastic_pipeline_stage_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [WIDTH-1:0] BUB  = WIDTH'(BUBBLE);
  localparam logic [PW-1:0]    LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0]    FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             flushed;
  logic             push;
  logic             pop;
  logic             ready;
  logic             valid;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at registered occupancy, so no Out_Ready path
  assign ready = (cnt != FULL);
  assign valid = (cnt != '0);
  assign push  = bus.In_Valid & ready;
  assign pop   = valid & bus.Out_Ready;

  assign bus.In_Ready  = ready;
  assign bus.Out_Valid = valid;
  assign bus.Out_Data  = valid ? mem[rd_ptr] : BUB;
  assign bus.Count     = cnt;
  assign bus.Flushed   = flushed;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      flushed <= 1'b0;
    end else if (bus.Flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      flushed <= valid;
    end else begin
      flushed <= 1'b0;
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is never cleared; only the pointers define what is live
  always_ff @(posedge CLK) begin
    if (!RST && !bus.Flush && push) begin
      mem[wr_ptr] <= bus.In_Data;
    end
  end
endmodule
